// File: rtl/gpu_rect_filler_pkg.sv
// Shared definitions for the rectangle-fill front end: GPU register map,
// ENABLE bit layout, FSM encoding and the clipping helper.
package gpu_rect_filler_pkg;

    localparam logic [7:0] REG_X_POS  = 8'd0;
    localparam logic [7:0] REG_Y_POS  = 8'd1;
    localparam logic [7:0] REG_PIXEL  = 8'd2;
    localparam logic [7:0] REG_LEN    = 8'd3;
    localparam logic [7:0] REG_ENABLE = 8'd4;
    localparam logic [7:0] REG_BUSY   = 8'd7;

    localparam int EN_START       = 0;
    localparam int EN_BUFFER_MODE = 1;

    // START set, BUFFER_MODE clear: solid-colour fill of the current row.
    localparam logic [31:0] EN_SOLID_START = 32'(1) << EN_START;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_X,
        S_WR_PIX,
        S_WR_LEN,
        S_WR_Y,
        S_WR_EN,
        S_WAIT_HI,
        S_WAIT_LO,
        S_WR_DIS,
        S_SETTLE,
        S_NEXT,
        S_ABORT,
        S_DONE
    } state_t;

    // min(len, limit - pos); only meaningful when pos < limit.
    function automatic logic [16:0] clip_len(input logic [16:0] pos,
                                             input logic [16:0] len,
                                             input logic [16:0] limit);
        logic [16:0] room;
        room = limit - pos;
        return (len > room) ? room : len;
    endfunction

endpackage

// File: rtl/gpu_reg_writer.sv
// Registered single-cycle write strobe into the GPU register file:
// byte enables are 4'hF only in the cycle following a write request.
module gpu_reg_writer
    import gpu_rect_filler_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [7:0]  gpu_addr_in,
    output logic [3:0]  gpu_size_decode,
    output logic [31:0] gpu_data_in
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gpu_addr_in     <= REG_X_POS;
            gpu_size_decode <= 4'h0;
            gpu_data_in     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so ordering between blocks cannot race.
            gpu_size_decode <= wr_en ? 4'hF : 4'h0;
            if (wr_en) begin
                gpu_addr_in <= wr_addr;
                gpu_data_in <= wr_data;
            end
        end
    end

endmodule

// File: rtl/gpu_rect_filler.sv
// Breaks one solid-colour rectangle command into per-row GPU fill jobs,
// handshaking each row through the GPU ENABLE/BUSY registers.
module gpu_rect_filler
    import gpu_rect_filler_pkg::*;
#(
    parameter int H_DISP        = 1024,
    parameter int V_DISP        = 600,
    parameter int SETTLE_CYCLES = 8,
    parameter int RISE_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    input  logic [15:0] cmd_w,
    input  logic [15:0] cmd_h,
    input  logic [23:0] cmd_rgb,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic        cmd_err,
    output logic [7:0]  gpu_addr_in,
    output logic [3:0]  gpu_size_decode,
    output logic [31:0] gpu_data_in,
    output logic [7:0]  gpu_addr_out,
    input  logic [31:0] gpu_data_out
);

    localparam logic [16:0] H_LIM = 17'(H_DISP);
    localparam logic [16:0] V_LIM = 17'(V_DISP);

    state_t      state_q, state_d;
    logic [15:0] x_q, weff_q, row_q, row_d, row_last_q, cnt_q, cnt_d;
    logic [23:0] rgb_q;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, abort_q, abort_d;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        accept, degenerate, busy_bit;
    logic [16:0] weff_c, heff_c;
    logic        unused_read_bits;

    assign busy_bit         = gpu_data_out[0];
    assign unused_read_bits = ^gpu_data_out[31:1];
    assign accept           = (state_q == S_IDLE) && cmd_valid;

    assign degenerate = ({1'b0, cmd_x} >= H_LIM) || ({1'b0, cmd_y} >= V_LIM) ||
                        (cmd_w == 16'd0) || (cmd_h == 16'd0);
    assign weff_c = clip_len({1'b0, cmd_x}, {1'b0, cmd_w}, H_LIM);
    assign heff_c = clip_len({1'b0, cmd_y}, {1'b0, cmd_h}, V_LIM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            row_q      <= '0;
            row_last_q <= '0;
            x_q        <= '0;
            weff_q     <= '0;
            rgb_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            abort_q <= abort_d;
            if (accept) begin
                x_q        <= cmd_x;
                rgb_q      <= cmd_rgb;
                weff_q     <= 16'(weff_c);
                row_q      <= cmd_y;
                row_last_q <= 16'({1'b0, cmd_y} + heff_c - 17'd1);
            end else begin
                row_q <= row_d;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        abort_d = abort_q;
        wr_en   = 1'b0;
        wr_addr = REG_X_POS;
        wr_data = '0;
        unique case (state_q)
            S_IDLE: if (cmd_valid) begin
                busy_d  = 1'b1;
                abort_d = 1'b0;
                state_d = degenerate ? S_DONE : S_WR_X;
            end
            S_WR_X:   begin wr_en = 1'b1; wr_addr = REG_X_POS; wr_data = {16'h0, x_q};    state_d = S_WR_PIX; end
            S_WR_PIX: begin wr_en = 1'b1; wr_addr = REG_PIXEL; wr_data = {8'h0, rgb_q};   state_d = S_WR_LEN; end
            S_WR_LEN: begin wr_en = 1'b1; wr_addr = REG_LEN;   wr_data = {16'h0, weff_q}; state_d = S_WR_Y;   end
            S_WR_Y:   begin wr_en = 1'b1; wr_addr = REG_Y_POS; wr_data = {16'h0, row_q};  state_d = S_WR_EN;  end
            S_WR_EN: begin
                wr_en   = 1'b1;
                wr_addr = REG_ENABLE;
                wr_data = EN_SOLID_START;
                cnt_d   = '0;
                state_d = S_WAIT_HI;
            end
            // The first two read samples predate the ENABLE write and are stale.
            S_WAIT_HI: begin
                if (cnt_q >= 16'd2 && busy_bit)            state_d = S_WAIT_LO;
                else if (cnt_q == 16'(RISE_TIMEOUT - 1))   state_d = S_ABORT;
                else                                       cnt_d   = cnt_q + 16'd1;
            end
            S_WAIT_LO: if (!busy_bit) state_d = S_WR_DIS;
            S_WR_DIS: begin
                wr_en   = 1'b1;
                wr_addr = REG_ENABLE;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 16'(SETTLE_CYCLES - 1)) state_d = S_NEXT;
                else                                 cnt_d   = cnt_q + 16'd1;
            end
            S_NEXT: begin
                if (row_q == row_last_q) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + 16'd1;
                    state_d = S_WR_Y;
                end
            end
            S_ABORT: begin
                wr_en   = 1'b1;
                wr_addr = REG_ENABLE;
                abort_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                err_d   = abort_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    gpu_reg_writer u_writer (
        .clk             (clk),
        .rstn            (rstn),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .gpu_addr_in     (gpu_addr_in),
        .gpu_size_decode (gpu_size_decode),
        .gpu_data_in     (gpu_data_in)
    );

    assign cmd_busy     = busy_q;
    assign cmd_done     = done_q;
    assign cmd_err      = err_q;
    assign gpu_addr_out = REG_BUSY;

endmodule

// File: tb/tb_gpu_rect_filler.sv
// Bench for gpu_rect_filler: GPU register-file model with a BUSY responder,
// write scoreboard, command table plus hand-written corner sequences.
module tb_gpu_rect_filler;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [23:0] cmd_rgb = '0;
    logic        cmd_busy, cmd_done, cmd_err;
    logic [7:0]  gpu_addr_in, gpu_addr_out;
    logic [3:0]  gpu_size_decode;
    logic [31:0] gpu_data_in;
    logic [31:0] gpu_data_out = '0;

    always #5 clk = ~clk;

    gpu_rect_filler dut (
        .clk             (clk),
        .rstn            (rstn),
        .cmd_valid       (cmd_valid),
        .cmd_x           (cmd_x),
        .cmd_y           (cmd_y),
        .cmd_w           (cmd_w),
        .cmd_h           (cmd_h),
        .cmd_rgb         (cmd_rgb),
        .cmd_busy        (cmd_busy),
        .cmd_done        (cmd_done),
        .cmd_err         (cmd_err),
        .gpu_addr_in     (gpu_addr_in),
        .gpu_size_decode (gpu_size_decode),
        .gpu_data_in     (gpu_data_in),
        .gpu_addr_out    (gpu_addr_out),
        .gpu_data_out    (gpu_data_out)
    );

    typedef struct {
        logic [15:0] x, y, w, h;
        logic [23:0] rgb;
        int          len;
        int          rows;
        bit          never_busy;
        bit          exp_err;
    } cmd_rec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t      exp_q[$];
    wr_t      e_w;
    cmd_rec_t tbl[7];
    cmd_rec_t hand;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, done_start = 0, done_cyc = 0, acc_cyc = 0;
    int en1_cyc = 0, en0_cyc = 0, hi_at = -1, lo_at = -1;
    bit last_err = 1'b0, never_busy = 1'b0, model_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // GPU model: consumes writes against the scoreboard, answers BUSY reads.
    always @(negedge clk) begin
        if (!rstn) begin
            hi_at        = -1;
            lo_at        = -1;
            model_busy   = 1'b0;
            gpu_data_out = '0;
        end else begin
            if (gpu_size_decode == 4'hF) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, none required", gpu_addr_in, gpu_data_in);
                end else begin
                    e_w = exp_q.pop_front();
                    check("write_addr", gpu_addr_in, e_w.addr);
                    check("write_data", gpu_data_in, e_w.data);
                end
                if (gpu_addr_in == 8'd4 && gpu_data_in[0]) begin
                    en1_cyc = cyc;
                    if (!never_busy) begin
                        hi_at = cyc + 5;
                        lo_at = cyc + 45;
                    end
                end
                if (gpu_addr_in == 8'd4 && !gpu_data_in[0]) en0_cyc = cyc;
            end
            if (cmd_done) begin
                done_cnt++;
                last_err = cmd_err;
                done_cyc = cyc;
            end else if (cmd_err) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_err: cmd_err=1 without cmd_done at cycle %0d", cyc);
            end
            model_busy   = (hi_at >= 0) && (cyc >= hi_at) && (cyc < lo_at);
            gpu_data_out = {31'b0, model_busy};
        end
    end

    task automatic push_expected(input cmd_rec_t r);
        int n;
        if (r.rows == 0) return;
        exp_q.push_back('{addr: 8'd0, data: {16'h0, r.x}});
        exp_q.push_back('{addr: 8'd2, data: {8'h0, r.rgb}});
        exp_q.push_back('{addr: 8'd3, data: 32'(r.len)});
        n = r.exp_err ? 1 : r.rows;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{addr: 8'd1, data: 32'(r.y) + 32'(i)});
            exp_q.push_back('{addr: 8'd4, data: 32'h1});
            exp_q.push_back('{addr: 8'd4, data: 32'h0});
        end
    endtask

    task automatic issue(input cmd_rec_t r);
        never_busy = r.never_busy;
        push_expected(r);
        @(negedge clk);
        cmd_x = r.x; cmd_y = r.y; cmd_w = r.w; cmd_h = r.h; cmd_rgb = r.rgb;
        cmd_valid  = 1'b1;
        acc_cyc    = cyc;
        done_start = done_cnt;
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
        check("busy_after_accept", cmd_busy, 1);
    endtask

    task automatic wait_done(input cmd_rec_t r);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (done_cnt != done_start) break;
        end
        check("done_pulse_seen", done_cnt - done_start, 1);
        repeat (4) @(posedge clk);
        check("done_pulse_count", done_cnt - done_start, 1);
        check("err_with_done", last_err, r.exp_err);
        check("writes_outstanding", exp_q.size(), 0);
        if (r.rows == 0) check("degenerate_latency", done_cyc - acc_cyc, 2);
        if (r.exp_err) begin
            check("timeout_gap_in_range", (en0_cyc - en1_cyc >= 1024) && (en0_cyc - en1_cyc <= 1030), 1);
            check("done_after_abort_write", done_cyc - en0_cyc, 1);
        end
        exp_q.delete();
    endtask

    initial begin
        tbl[0] = '{x: 16'd10,   y: 16'd20,  w: 16'd100, h: 16'd3,  rgb: 24'hFF0000, len: 100, rows: 3, never_busy: 1'b0, exp_err: 1'b0};
        tbl[1] = '{x: 16'd1000, y: 16'd595, w: 16'd100, h: 16'd20, rgb: 24'h00FF00, len: 24,  rows: 5, never_busy: 1'b0, exp_err: 1'b0};
        tbl[2] = '{x: 16'd10,   y: 16'd20,  w: 16'd0,   h: 16'd5,  rgb: 24'h123456, len: 0,   rows: 0, never_busy: 1'b0, exp_err: 1'b0};
        tbl[3] = '{x: 16'd1024, y: 16'd20,  w: 16'd10,  h: 16'd5,  rgb: 24'h123456, len: 0,   rows: 0, never_busy: 1'b0, exp_err: 1'b0};
        tbl[4] = '{x: 16'd0,    y: 16'd600, w: 16'd10,  h: 16'd10, rgb: 24'h654321, len: 0,   rows: 0, never_busy: 1'b0, exp_err: 1'b0};
        tbl[5] = '{x: 16'd1023, y: 16'd599, w: 16'd5,   h: 16'd5,  rgb: 24'h0A0B0C, len: 1,   rows: 1, never_busy: 1'b0, exp_err: 1'b0};
        tbl[6] = '{x: 16'd5,    y: 16'd7,   w: 16'd3,   h: 16'd2,  rgb: 24'h00AA55, len: 3,   rows: 2, never_busy: 1'b1, exp_err: 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check("reset_cmd_busy", cmd_busy, 0);
        check("reset_cmd_done", cmd_done, 0);
        check("reset_cmd_err", cmd_err, 0);
        check("reset_size_decode", gpu_size_decode, 0);
        check("reset_addr_in", gpu_addr_in, 0);
        check("reset_data_in", gpu_data_in, 0);
        check("reset_addr_out", gpu_addr_out, 8'd7);
        rstn = 1'b1;

        for (int t = 0; t < 7; t++) begin
            issue(tbl[t]);
            wait_done(tbl[t]);
        end

        // cmd_valid during an active command must be ignored.
        hand = '{x: 16'd4, y: 16'd8, w: 16'd16, h: 16'd2, rgb: 24'h123456, len: 16, rows: 2, never_busy: 1'b0, exp_err: 1'b0};
        issue(hand);
        repeat (20) @(negedge clk);
        cmd_x = 16'd700; cmd_y = 16'd100; cmd_w = 16'd9; cmd_h = 16'd9; cmd_rgb = 24'hABCDEF;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(hand);

        // Reset while the DUT waits for BUSY to fall.
        hand = '{x: 16'd10, y: 16'd30, w: 16'd50, h: 16'd3, rgb: 24'h0000FF, len: 50, rows: 3, never_busy: 1'b0, exp_err: 1'b0};
        issue(hand);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (model_busy) break;
        end
        check("busy_rose_before_reset", model_busy, 1);
        repeat (5) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midreset_cmd_busy", cmd_busy, 0);
        check("midreset_cmd_done", cmd_done, 0);
        check("midreset_cmd_err", cmd_err, 0);
        check("midreset_size_decode", gpu_size_decode, 0);
        check("midreset_addr_in", gpu_addr_in, 0);
        check("midreset_data_in", gpu_data_in, 0);
        check("midreset_addr_out", gpu_addr_out, 8'd7);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        check("no_done_after_reset", done_cnt - done_start, 0);
        issue(tbl[0]);
        wait_done(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
